mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit for the pipelined RV32I core. It sits directly downstream of the E→M control register and consumes `MemWriteM`, `ResultSrcM`, `funct3M` and the E→M datapath values `ALUResultM` and `WriteDataM`. It drives a single-outstanding request/grant/response data-memory bus and returns sign- or zero-extended load data to the M→W register. While an access is in flight it raises `StallM` to the hazard unit.

## Interface
- `ADDR_W`, 32, bus address width.
- `DATA_W`, 32, bus data width; only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `MemWriteM`  in  1  store in M.
- `ResultSrcM`  in  2  `2'b01` marks a load in M.
- `funct3M`  in  3  access size and sign.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data, right-aligned.
- `StallM`  out  1  freeze F/D/E/M registers, bubble W.
- `ReadDataM`  out  32  extended load data; valid in the DONE cycle.
- `MisalignM`  out  1  misaligned-access flag; present only with the macro.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  write request.
- `dmem_addr`  out  32  word-aligned address, `{ALUResultM[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  response, for loads and stores alike.
- `dmem_rdata`  in  32  read word.

## Operation
- An access is `MemWriteM | (ResultSrcM==2'b01)`.
- FSM states:
  - IDLE, reset state:
    - Access present: drive `dmem_req=1`, `StallM=1`.
    - `gnt & !rvalid` → WAIT.
    - `gnt & rvalid` → DONE, capturing data.
    - `!gnt`: stay in IDLE. M inputs are frozen by the stall, so the request is held stable.
  - WAIT:
    - `dmem_req=0`, `StallM=1`.
    - `rvalid` → DONE, latch `dmem_rdata` into `rdata_q`.
  - DONE:
    - `StallM=0`. `ReadDataM` is taken from `rdata_q` after extraction.
    - Always → IDLE. This transition coincides with M advancing.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
- Store data: byte replicated ×4, half replicated ×2, word passed through.
- Load extraction:
  - Shift `rdata_q` right by `addr[1:0]*8`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined `funct3`: treated as LW.
- Bus outputs are 0 whenever `dmem_req=0`.
- `ReadDataM=0` outside DONE and for stores.
- `rvalid` in IDLE with no access is ignored. This covers stale responses after reset.

## Timing
- After reset: all outputs 0, FSM in IDLE.
- Minimum access occupancy in M is 2 cycles: IDLE with `gnt & rvalid`, then DONE.
- Typical occupancy is 3 or more cycles: IDLE, WAIT×n, DONE.
- `StallM` is combinational from FSM state and M inputs; it is low for exactly one DONE cycle per access.
- Non-memory instructions pass through M in 1 cycle with `StallM=0`.
- Back-to-back accesses: the next request issues in the cycle after DONE.
- Reset mid-operation: immediate return to IDLE, outputs 0, the in-flight access is abandoned.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned cases are half with `addr[0]` set, or word with `addr[1:0]!=0`.
  - A misaligned access issues no bus request and keeps `StallM=0`.
  - `MisalignM=1` for that cycle.
- Undefined: no `MisalignM` port. Low address bits beyond the access size are ignored (half uses `addr[1]`, word uses none).

## Structure
- Package `riscv_pkg`:
  - `funct3` load/store encodings.
  - `RESULT_SRC_MEM = 2'b01`.
  - `lsu_state_t` enum {IDLE, WAIT, DONE}.
- Sub-module `lsu_align`: combinational byte-enable generation, store-data replication and load extract/extend. Instantiated once.

## Test plan
- SW 0xDEADBEEF to 0x100, `gnt` in cycle 0, `rvalid` in cycle 2 → `be=1111`, `we=1`, `StallM` high 3 cycles then low 1 cycle.
- LB from 0x103, `rdata=0x80FF_FF7F`, `gnt+rvalid` same cycle → `ReadDataM=0xFFFF_FF80`, 2-cycle occupancy.
- LHU from 0x102, `rdata=0x8001_1234` → `ReadDataM=0x0000_8001`; SH 0xABCD to 0x102 → `be=1100`, `wdata=0xABCD_ABCD`.
- `gnt` withheld for 4 cycles on a load → `dmem_req` and `dmem_addr` stable for 4 cycles, `StallM` high throughout.
- `rst` asserted while in WAIT, then `rvalid` → FSM in IDLE, `ReadDataM=0`, no spurious DONE.
- With the macro, LW at 0x101 → no request, `MisalignM=1`, `StallM=0`; without the macro → `addr=0x100`, `be=1111`.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I memory stage.
//   - funct3 load/store encodings
//   - ResultSrc encoding that marks a load
//   - LSU FSM state type and access-size type
//   - accessSize(): funct3 -> access size (reserved sizes behave as word)
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

  // funct3[1:0] selects the size; 2'b11 and the other reserved codes act as word.
  function automatic lsu_size_t accessSize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   accessSize = SZ_BYTE;
      2'b01:   accessSize = SZ_HALF;
      default: accessSize = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the memory stage.
// Ports:
//   funct3    in   access size (bits [1:0]) and unsigned flag (bit 2)
//   addrLo    in   byte offset within the word
//   storeData in   right-aligned store data
//   rdataQ    in   captured read word
//   byteEn    out  byte enables for the bus
//   wdataRep  out  lane-replicated store data
//   loadData  out  extracted, sign/zero-extended load data
// Address bits below the access size are ignored: half uses addrLo[1], word none.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] rdataQ,
  output logic [3:0]  byteEn,
  output logic [31:0] wdataRep,
  output logic [31:0] loadData
);

  lsu_size_t   size;
  logic [31:0] shifted;

  always_comb begin
    size     = accessSize(funct3);
    byteEn   = 4'b1111;
    wdataRep = storeData;
    shifted  = rdataQ;
    loadData = rdataQ;
    case (size)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << addrLo;
        wdataRep = {4{storeData[7:0]}};
        shifted  = rdataQ >> {addrLo, 3'b000};
        loadData = funct3[2] ? {24'b0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byteEn   = 4'b0011 << {addrLo[1], 1'b0};
        wdataRep = {2{storeData[15:0]}};
        shifted  = rdataQ >> {addrLo[1], 4'b0000};
        loadData = funct3[2] ? {16'b0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byteEn   = 4'b1111;
        wdataRep = storeData;
        shifted  = rdataQ;
        loadData = rdataQ;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit, single outstanding access on a
// req/gnt/rvalid data bus. Holds the pipeline (StallM) until the response is in.
// Ports:
//   clk, rst                         clock, async active-high reset
//   MemWriteM, ResultSrcM, funct3M   M-stage control (store / load / size+sign)
//   ALUResultM, WriteDataM           effective byte address, store data
//   StallM                           freeze F/D/E/M, bubble W
//   ReadDataM                        extended load data, valid in DONE only
//   dmem_req/we/addr/be/wdata        bus request (all zero while dmem_req=0)
//   dmem_gnt, dmem_rvalid, dmem_rdata bus grant and response
//   MisalignM                        misaligned flag, only with LSU_MISALIGN_TRAP_EN
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word never issue).
//
// state | meaning
// IDLE  | no access in flight; issues request when M holds an access
// WAIT  | granted, waiting for rvalid
// DONE  | response captured; stall released, M advances next edge
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              MisalignM
`endif
);

  lsu_state_t  state, stateNext;
  logic [31:0] rdataQ;
  logic        isStore, isLoad, access, issue;
  logic [3:0]  byteEn;
  logic [31:0] wdataRep, loadData;

  assign isStore = MemWriteM;
  assign isLoad  = (ResultSrcM == RESULT_SRC_MEM) && !MemWriteM;
  assign access  = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);

`ifdef LSU_MISALIGN_TRAP_EN
  lsu_size_t sizeM;
  logic      misalign;
  assign sizeM     = accessSize(funct3M);
  assign misalign  = access && (((sizeM == SZ_HALF) && ALUResultM[0]) ||
                                ((sizeM == SZ_WORD) && (ALUResultM[1:0] != 2'b00)));
  assign issue     = access & ~misalign;
  assign MisalignM = misalign && (state == IDLE);
`else
  assign issue = access;
`endif

  lsu_align uAlign (
    .funct3    (funct3M),
    .addrLo    (ALUResultM[1:0]),
    .storeData (WriteDataM),
    .rdataQ    (rdataQ),
    .byteEn    (byteEn),
    .wdataRep  (wdataRep),
    .loadData  (loadData)
  );

  always_comb begin
    stateNext = state;
    dmem_req  = 1'b0;
    StallM    = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          dmem_req = 1'b1;
          StallM   = 1'b1;
          if (dmem_gnt) stateNext = dmem_rvalid ? DONE : WAIT;
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (dmem_rvalid) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      // capture on the response edge, whether it arrives with gnt or later
      if (((state == IDLE) && issue && dmem_gnt && dmem_rvalid) ||
          ((state == WAIT) && dmem_rvalid))
        rdataQ <= dmem_rdata;
    end
  end

  assign dmem_we    = dmem_req & isStore;
  assign dmem_addr  = dmem_req ? {ALUResultM[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? byteEn : 4'b0000;
  assign dmem_wdata = dmem_req ? wdataRep : '0;
  assign ReadDataM  = ((state == DONE) && isLoad) ? loadData : '0;

endmodule
